headgen_pipe_s4: RTL

- Downstream neighbour of headgen_pipe_s3. Consumes its out_0/out_1/out_2/enableout stream, one header per burst.
- Accumulates the per-cycle 16-bit partial sums into a one's-complement header checksum and buffers the header bytes.
- Replays the header with the inverted checksum inserted at a fixed byte offset, ready for the encapsulation mux.

---
 rtl/headgen_pkg.sv | 20 ++
 rtl/headgen_csum_acc.sv | 38 +++
 rtl/headgen_pipe_s4.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/headgen_pkg.sv
// Shared definitions for the header-generation pipeline: default sizes, FSM
// state encoding and the one's-complement end-around-carry fold.
package headgen_pkg;

    localparam int unsigned HDR_BYTES_DEF = 20;
    localparam int unsigned CSUM_OFS_DEF  = 10;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFold    = 2'd2,
        StEmit    = 2'd3
    } hg_state_e;

    // Adds the carry bits [17:16] back into the low 16 bits; result may still carry once.
    function automatic logic [16:0] csum_fold(input logic [17:0] x);
        return {1'b0, x[15:0]} + {15'b0, x[17:16]};
    endfunction

endpackage

// File: rtl/headgen_csum_acc.sv
// One's-complement checksum accumulator: adds two 16-bit partial sums per
// enabled cycle; clr_i restarts the sum from zero in the same cycle.
module headgen_csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] acc_o
);
    import headgen_pkg::*;

    logic [15:0] acc_q;
    logic [15:0] acc_d;
    logic [15:0] base;
    logic [17:0] sum;
    logic [16:0] fold1;

    always_comb begin
        base  = clr_i ? 16'h0000 : acc_q;
        sum   = {2'b00, base} + {2'b00, a_i} + {2'b00, b_i};
        fold1 = csum_fold(sum);
        // Second fold absorbs the single carry the first one can leave behind.
        acc_d = 16'(csum_fold({1'b0, fold1}));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 16'h0000;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/headgen_pipe_s4.sv
// Header capture, checksum insertion and replay stage.
// Optional HEADGEN_S4_STATS_EN adds a wrapping emitted-header counter (hdr_count).
module headgen_pipe_s4
    import headgen_pkg::*;
#(
    parameter int unsigned HDR_BYTES = HDR_BYTES_DEF,
    parameter int unsigned CSUM_OFS  = CSUM_OFS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  in_0,
    input  logic [15:0] in_1,
    input  logic [15:0] in_2,
    input  logic        enablein,
    output logic [8:0]  out_0,
    output logic [15:0] out_csum,
    output logic        enableout,
    output logic        busy,
`ifdef HEADGEN_S4_STATS_EN
    output logic [15:0] hdr_count,
`endif
    output logic        overrun
);

    localparam int unsigned CntW = $clog2(HDR_BYTES + 1);
    localparam int unsigned IdxW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    hg_state_e       state_q, state_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;
    logic [CntW-1:0] ecnt_q, ecnt_d;
    logic [15:0]     csum_q, csum_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      hdr_buf [HDR_BYTES];
    logic [15:0]     acc;

    logic            start;
    logic            cap_ok;
    logic            full;
    logic            last_byte;
    logic            wr_en;
    logic [IdxW-1:0] wr_idx;
    logic [7:0]      emit_byte;

    always_comb begin
        full      = (wcnt_q == CntW'(HDR_BYTES));
        start     = (state_q == StIdle) && enablein && in_0[8];
        cap_ok    = (state_q == StCapture) && enablein && !full;
        last_byte = (state_q == StEmit) && (ecnt_q == wcnt_q - CntW'(1));
        wr_en     = start || cap_ok;
        wr_idx    = start ? '0 : wcnt_q[IdxW-1:0];
    end

    headgen_csum_acc u_csum_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .en_i  (wr_en),
        .a_i   (in_1),
        .b_i   (in_2),
        .acc_o (acc)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCapture;
            StCapture: if (!enablein) state_d = StFold;
            StFold:    state_d = StEmit;
            StEmit:    if (last_byte) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Counters, checksum and error flag
    always_comb begin
        wcnt_d    = wcnt_q;
        ecnt_d    = ecnt_q;
        csum_d    = csum_q;
        overrun_d = overrun_q;
        if (start) begin
            wcnt_d = CntW'(1);
            csum_d = 16'h0000;
        end else if (cap_ok) begin
            wcnt_d = wcnt_q + CntW'(1);
        end
        if (state_q == StFold) begin
            csum_d = ~acc;
            ecnt_d = '0;
        end else if (state_q == StEmit) begin
            ecnt_d = ecnt_q + CntW'(1);
        end
        if (enablein && (((state_q == StCapture) && full) ||
                         (state_q == StFold) || (state_q == StEmit))) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_q    <= '0;
            ecnt_q    <= '0;
            csum_q    <= 16'h0000;
            overrun_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            ecnt_q    <= ecnt_d;
            csum_q    <= csum_d;
            overrun_q <= overrun_d;
        end
    end

    // Header bytes need no reset: only indices below wcnt are ever replayed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            hdr_buf[wr_idx] <= in_0[7:0];
        end
    end

    // FSM outputs
    always_comb begin
        out_0     = 9'h000;
        enableout = 1'b0;
        emit_byte = hdr_buf[ecnt_q[IdxW-1:0]];
        if (ecnt_q == CntW'(CSUM_OFS)) begin
            emit_byte = csum_q[15:8];
        end else if (ecnt_q == CntW'(CSUM_OFS + 1)) begin
            emit_byte = csum_q[7:0];
        end
        if (state_q == StEmit) begin
            enableout = 1'b1;
            out_0     = {(ecnt_q == '0), emit_byte};
        end
    end

    assign busy     = (state_q != StIdle);
    assign out_csum = csum_q;
    assign overrun  = overrun_q;

`ifdef HEADGEN_S4_STATS_EN
    logic [15:0] hdr_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_count_q <= 16'h0000;
        end else if (last_byte) begin
            hdr_count_q <= hdr_count_q + 16'h0001;
        end
    end

    assign hdr_count = hdr_count_q;
`endif

endmodule
